// File: rtl/mmio_int_ctrl.sv
// Memory-mapped vectored interrupt controller: fixed-priority arbitration of N sources,
// handshake with the cpu via int_req/int_ack/int_done. Reads are combinational; writes land on the clock edge.
module mmio_int_ctrl #(
  parameter int            DW         = 8,
  parameter int            AW         = 8,
  parameter int            N          = 4,
  parameter logic [AW-1:0] BASE       = 8'd240,
  parameter int            VEC_STRIDE = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] w_data,
  input  logic          w_en,
  output logic [DW-1:0] r_data,
  output logic          r_hit,
  input  logic [N-1:0]  irq_src,
  input  logic          int_ack,
  input  logic          int_done,
  output logic          int_req,
  output logic [DW-1:0] int_vec,
  output logic [DW-1:0] int_en
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;

  logic [DW-1:0] vbase;
  logic [N-1:0]  enable, pend, mode, src_q;
  logic          gie;
  logic [IW-1:0] id;

  logic [AW-1:0] off;
  logic          we;
  logic [N-1:0]  rise, w1c, ack_clr;
  logic [N-1:0]  enable_n, mode_n, pend_n;
  logic          gie_n;
  logic [N-1:0]  peff, elig, peff_n, elig_n;
  logic [IW-1:0] win;
  logic [DW-1:0] vec_calc;

  assign off   = addr - BASE;
  assign r_hit = (off < AW'(6));
  assign we    = w_en & r_hit;

  always_comb begin
    r_data = '0;
    if (r_hit) begin
      case (off[2:0])
        3'd0: r_data = vbase;
        3'd1: r_data = DW'(enable);
        3'd2: r_data = DW'(peff);
        3'd3: begin
          r_data[IW-1:0] = id;
          r_data[DW-1]   = (state == SERVICE);
        end
        3'd4: r_data = DW'(gie);
        3'd5: r_data = DW'(mode);
        default: r_data = '0;
      endcase
    end
  end

  // Edge-mode pending is stored; level-mode pending is just the registered source copy.
  assign rise     = irq_src & ~src_q;
  assign w1c      = (we && off == AW'(2)) ? w_data[N-1:0] : '0;
  assign ack_clr  = (state == REQ && int_ack) ? (N'(1) << id) : '0;
  assign enable_n = (we && off == AW'(1)) ? w_data[N-1:0] : enable;
  assign gie_n    = (we && off == AW'(4)) ? w_data[0] : gie;
  assign mode_n   = (we && off == AW'(5)) ? w_data[N-1:0] : mode;
  assign pend_n   = ((pend & ~w1c & ~ack_clr) | rise) & ~mode_n;

  assign peff   = (pend & ~mode) | (src_q & mode);
  assign elig   = gie ? (peff & enable) : '0;
  // Next-cycle eligibility lets a W1C/disable in REQ withdraw the request on the very next edge.
  assign peff_n = pend_n | (irq_src & mode_n);
  assign elig_n = gie_n ? (peff_n & enable_n) : '0;

  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) win = IW'(i);
    end
  end

  assign vec_calc = vbase + DW'(win) * DW'(VEC_STRIDE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      vbase   <= '0;
      enable  <= '0;
      pend    <= '0;
      mode    <= '0;
      gie     <= 1'b0;
      src_q   <= '0;
      id      <= '0;
      int_req <= 1'b0;
      int_vec <= '0;
      int_en  <= '0;
    end else begin
      if (we && off == AW'(0)) vbase <= w_data;
      enable <= enable_n;
      gie    <= gie_n;
      mode   <= mode_n;
      pend   <= pend_n;
      src_q  <= irq_src;
      case (state)
        IDLE: begin
          if (|elig) begin
            state   <= REQ;
            id      <= win;
            int_vec <= vec_calc;
            int_req <= 1'b1;
            int_en  <= '0;
          end else begin
            int_en <= DW'(gie_n);
          end
        end
        REQ: begin
          if (int_ack) begin
            state   <= SERVICE;
            int_req <= 1'b0;
          end else if (!elig_n[id]) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_en  <= DW'(gie_n);
          end
        end
        SERVICE: begin
          if (int_done) begin
            state  <= IDLE;
            int_en <= DW'(gie_n);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_int_ctrl.sv
// Directed bench for mmio_int_ctrl: register map, edge/level pending, arbitration and handshake.
module tb_mmio_int_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] addr, w_data, r_data, int_vec, int_en;
  logic       w_en, r_hit, int_ack, int_done, int_req;
  logic [3:0] irq_src;

  int checks = 0;
  int errors = 0;

  mmio_int_ctrl dut (
    .clock(clock), .reset(reset), .addr(addr), .w_data(w_data), .w_en(w_en),
    .r_data(r_data), .r_hit(r_hit), .irq_src(irq_src), .int_ack(int_ack),
    .int_done(int_done), .int_req(int_req), .int_vec(int_vec), .int_en(int_en)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, r_data, exp);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1; step(); int_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 8'd0; w_data = 8'd0; w_en = 1'b0;
    irq_src = 4'd0; int_ack = 1'b0; int_done = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state and address decode
    chk("rst_int_req", {7'd0, int_req}, 8'h00);
    chk("rst_int_vec", int_vec, 8'h00);
    chk("rst_int_en", int_en, 8'h00);
    for (int a = 240; a <= 245; a++) begin
      rd("rst_reg", 8'(a), 8'h00);
      chk("hit_in", {7'd0, r_hit}, 8'h01);
    end
    rd("miss_lo_data", 8'd239, 8'h00);
    chk("miss_lo_hit", {7'd0, r_hit}, 8'h00);
    rd("miss_hi_data", 8'd246, 8'h00);
    chk("miss_hi_hit", {7'd0, r_hit}, 8'h00);

    // Single edge request on source 2
    wr(8'd240, 8'h80);
    wr(8'd241, 8'h0F);
    wr(8'd244, 8'h01);
    rd("vbase_rb", 8'd240, 8'h80);
    rd("enable_rb", 8'd241, 8'h0F);
    chk("gie_int_en", int_en, 8'h01);
    irq_src = 4'b0100; step(); irq_src = 4'b0000;
    rd("pend_src2", 8'd242, 8'h04);
    chk("req_not_yet", {7'd0, int_req}, 8'h00);
    step();
    chk("req_src2", {7'd0, int_req}, 8'h01);
    chk("vec_src2", int_vec, 8'h88);
    chk("req_int_en", int_en, 8'h00);
    pulse_ack();
    chk("req_after_ack", {7'd0, int_req}, 8'h00);
    rd("pend_after_ack", 8'd242, 8'h00);
    rd("status_svc2", 8'd243, 8'h82);
    pulse_done();
    chk("done_int_en", int_en, 8'h01);
    chk("done_int_req", {7'd0, int_req}, 8'h00);

    // Simultaneous rises on 3 and 1: lowest index wins, 3 follows
    irq_src = 4'b1010; step(); irq_src = 4'b0000;
    step();
    chk("vec_src1", int_vec, 8'h84);
    pulse_ack();
    pulse_done();
    chk("idle_gap", {7'd0, int_req}, 8'h00);
    step();
    chk("req_src3", {7'd0, int_req}, 8'h01);
    chk("vec_src3", int_vec, 8'h8C);
    pulse_ack();
    pulse_done();

    // W1C withdraws a pending request; set beats W1C in the same cycle
    irq_src = 4'b0100; step(); irq_src = 4'b0000;
    step();
    chk("req_w1c_pre", {7'd0, int_req}, 8'h01);
    wr(8'd242, 8'h04);
    chk("req_w1c_drop", {7'd0, int_req}, 8'h00);
    chk("w1c_idle_en", int_en, 8'h01);
    rd("status_w1c", 8'd243, 8'h02);
    irq_src = 4'b0001; addr = 8'd242; w_data = 8'h01; w_en = 1'b1;
    step();
    w_en = 1'b0; irq_src = 4'b0000;
    rd("pend_set_wins", 8'd242, 8'h01);
    step();
    chk("req_src0", {7'd0, int_req}, 8'h01);
    chk("vec_src0", int_vec, 8'h80);
    pulse_ack();
    pulse_done();

    // Level mode on source 0
    wr(8'd245, 8'h01);
    rd("mode_rb", 8'd245, 8'h01);
    irq_src = 4'b0001;
    step();
    rd("pend_level", 8'd242, 8'h01);
    step();
    chk("req_level", {7'd0, int_req}, 8'h01);
    pulse_ack();
    pulse_done();
    chk("level_idle", {7'd0, int_req}, 8'h00);
    step();
    chk("level_rereq", {7'd0, int_req}, 8'h01);
    wr(8'd242, 8'h01);
    chk("level_w1c_req", {7'd0, int_req}, 8'h01);
    rd("level_w1c_pend", 8'd242, 8'h01);
    pulse_ack();
    rd("status_svc0", 8'd243, 8'h80);

    // Reset from SERVICE
    irq_src = 4'b0000;
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_int_req", {7'd0, int_req}, 8'h00);
    chk("rst2_int_vec", int_vec, 8'h00);
    chk("rst2_int_en", int_en, 8'h00);
    rd("rst2_status", 8'd243, 8'h00);
    rd("rst2_enable", 8'd241, 8'h00);
    rd("rst2_mode", 8'd245, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
